// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: fetch PC, 2-entry prefetch buffer and valid/ready hand-off to decode.
// Optional perf counters (perf_fetch_cnt / perf_stall_cnt) are built when IFETCH_PERF_EN is defined.
module instr_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_STEP  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] END_PC     = 124
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] Read_address,
  input  logic [DATA_WIDTH-1:0] Instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  busy
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(ADDR_STEP - 1));

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic [1:0]              count_reg, count_next;
  logic [DATA_WIDTH-1:0]   head_instr_reg, head_instr_next;
  logic [ADDR_WIDTH-1:0]   head_pc_reg, head_pc_next;
  logic [DATA_WIDTH-1:0]   tail_instr_reg, tail_instr_next;
  logic [ADDR_WIDTH-1:0]   tail_pc_reg, tail_pc_next;
  logic                    pop;
  logic                    capture;

  assign Read_address = pc_reg;
  assign out_valid    = (count_reg != 2'd0);
  assign out_instr    = head_instr_reg;
  assign out_pc       = head_pc_reg;
  assign busy         = (state_reg == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      count_reg      <= 2'd0;
      head_instr_reg <= '0;
      head_pc_reg    <= '0;
      tail_instr_reg <= '0;
      tail_pc_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      count_reg      <= count_next;
      head_instr_reg <= head_instr_next;
      head_pc_reg    <= head_pc_next;
      tail_instr_reg <= tail_instr_next;
      tail_pc_reg    <= tail_pc_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    count_next      = count_reg;
    head_instr_next = head_instr_reg;
    head_pc_next    = head_pc_reg;
    tail_instr_next = tail_instr_reg;
    tail_pc_next    = tail_pc_reg;

    pop     = out_valid && out_ready;
    // A full buffer can only take a new word when the head leaves on the same edge.
    capture = (state_reg == RUN) && !redirect_valid && ((count_reg != 2'd2) || pop);

    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN:  if (capture && (pc_reg == END_PC)) state_next = DONE;
      DONE: if (redirect_valid) state_next = RUN;
      default: state_next = IDLE;
    endcase

    if (redirect_valid) begin
      pc_next    = redirect_pc & ALIGN_MASK;
      count_next = 2'd0;
    end else begin
      if (capture) pc_next = pc_reg + STEP;
      case (count_reg)
        2'd0: begin
          if (capture) begin
            head_instr_next = Instruction;
            head_pc_next    = pc_reg;
            count_next      = 2'd1;
          end
        end
        2'd1: begin
          if (pop && capture) begin
            head_instr_next = Instruction;
            head_pc_next    = pc_reg;
          end else if (pop) begin
            count_next = 2'd0;
          end else if (capture) begin
            tail_instr_next = Instruction;
            tail_pc_next    = pc_reg;
            count_next      = 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            head_instr_next = tail_instr_reg;
            head_pc_next    = tail_pc_reg;
            if (capture) begin
              tail_instr_next = Instruction;
              tail_pc_next    = pc_reg;
            end else begin
              count_next = 2'd1;
            end
          end
        end
        default: count_next = 2'd0;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic stall_cycle;
  assign stall_cycle = (state_reg == RUN) && (count_reg == 2'd2) && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (capture && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_cycle && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed phases plus random traffic, checked against a queue-based model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] Read_address;
  logic [31:0] Instruction;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .Read_address(Read_address), .Instruction(Instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Word n of the program lives at byte address 4n.
  always_comb Instruction = 32'h1000_0000 + (Read_address >> 2);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 = idle, 1 = fetching, 2 = finished.
  int          m_mode;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  longint      m_fetch, m_stall;
  int          dut_pops;
  logic [31:0] pop_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_q.delete(); m_fetch = 0; m_stall = 0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] rp, input logic rd);
    bit p;
    p = (m_q.size() != 0) && rd;
    if (m_mode == 1 && m_q.size() == 2 && !p) m_stall++;
    if (r) begin
      m_pc = {rp[31:2], 2'b00};
      m_q.delete();
      if (m_mode == 2 || (m_mode == 0 && s)) m_mode = 1;
    end else begin
      if (p) void'(m_q.pop_front());
      if (m_mode == 1 && m_q.size() < 2) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_fetch++;
        if (m_pc == 32'd124) m_mode = 2;
        m_pc = m_pc + 32'd4;
      end else if (m_mode == 0 && s) begin
        m_mode = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk({tag, ".out_pc"},    64'(out_pc),    64'(m_q[0][63:32]));
      chk({tag, ".out_instr"}, 64'(out_instr), 64'(m_q[0][31:0]));
    end
    chk({tag, ".Read_address"}, 64'(Read_address), 64'(m_pc));
    chk({tag, ".busy"}, 64'(busy), 64'(m_mode == 1));
`ifdef IFETCH_PERF_EN
    chk({tag, ".perf_fetch"}, 64'(perf_fetch_cnt), 64'(m_fetch));
    chk({tag, ".perf_stall"}, 64'(perf_stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic tick(input string tag, input logic s, input logic r,
                      input logic [31:0] rp, input logic rd);
    @(negedge clk);
    start = s; redirect_valid = r; redirect_pc = rp; out_ready = rd;
    #1;
    if (out_valid && out_ready) begin
      dut_pops++;
      pop_log.push_back(out_pc);
      $display("pop pc=%08h instr=%08h", out_pc, out_instr);
    end
    @(posedge clk);
    model_step(s, r, rp, rd);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    dut_pops = 0;
    #1;
    chk("reset.out_instr", 64'(out_instr), 64'h0);
    chk("reset.out_pc", 64'(out_pc), 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Idle with no start.
    for (int i = 0; i < 5; i++) tick("idle", 1'b0, 1'b0, 32'h0, 1'b1);

    // Full program streamed with decode always ready.
    dut_pops = 0;
    tick("start", 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 40; i++) tick("stream", 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stream.words_delivered", 64'(dut_pops), 64'd32);
    chk("stream.done_not_busy", 64'(busy), 64'd0);

    // Redirect out of DONE with decode stalled: buffer fills, PC holds at 8.
    tick("restart", 1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick("stall", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall.read_address", 64'(Read_address), 64'h8);
    chk("stall.out_pc", 64'(out_pc), 64'h0);
    pop_log.delete();
    for (int i = 0; i < 3; i++) tick("drain", 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain.n", 64'(pop_log.size()), 64'd3);
    if (pop_log.size() == 3) begin
      chk("drain.pc0", 64'(pop_log[0]), 64'h0);
      chk("drain.pc1", 64'(pop_log[1]), 64'h4);
      chk("drain.pc2", 64'(pop_log[2]), 64'h8);
    end

    // Redirect to an unaligned target while full.
    for (int i = 0; i < 3; i++) tick("refill", 1'b0, 1'b0, 32'h0, 1'b0);
    tick("redir", 1'b0, 1'b1, 32'h0000_0043, 1'b0);
    chk("redir.out_valid", 64'(out_valid), 64'd0);
    chk("redir.read_address", 64'(Read_address), 64'h40);
    tick("redir_cap", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir.out_pc", 64'(out_pc), 64'h40);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      tick("rand", 1'(($urandom % 8) == 0), 1'(($urandom % 12) == 0),
           32'($urandom % 256), 1'(($urandom % 3) != 0));

    // Asynchronous reset in the middle of a run.
    tick("pre_rst", 1'b0, 1'b1, 32'h20, 1'b1);
    for (int i = 0; i < 3; i++) tick("pre_rst", 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.read_address", 64'(Read_address), 64'h0);
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.out_pc", 64'(out_pc), 64'h0);
    chk("arst.out_instr", 64'(out_instr), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick("restart2", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) tick("after_rst", 1'b0, 1'b0, 32'h0, 1'($urandom % 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
